// File: rtl/att_lookup_scheduler.sv
// -----------------------------------------------------------------------------
// att_lookup_scheduler
//
// Purpose:
//   Shares the single read port of the literal-to-clause address translation
//   table between two walk-SAT requesters (req0 = flip/make unit, req1 =
//   break-value unit). Grants round-robin on ties, covers the table's 1-cycle
//   registered read latency with an in-flight stage, and parks results in a
//   2-entry show-ahead response FIFO. Issue is credit-based: a grant is only
//   given when the in-flight slot plus the FIFO can still hold the result, so
//   downstream backpressure never drops a lookup. Table setup writes do not
//   pass through here.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   cfg_lock_i            table setup in progress; no new grants while high
//   reqN_valid_i/_lit_i   lookup request from requester N (N = 0, 1)
//   reqN_ready_o          request N accepted this cycle (combinational)
//   att_rd_addr_o         table read address (granted literal, else held)
//   att_addr_i/_mask_i    table read data, valid the cycle after the address
//   rsp_valid_o/_ready_i  response handshake
//   rsp_addr_o/_mask_o    clause table address and mask from the table
//   rsp_id_o              originating requester
//   rsp_lit_o             literal echoed back
//   busy_o                lookup in flight or responses buffered
//
// Build option:
//   ATT_LOOKUP_STATS_EN   adds stat_clr_i and saturating counters
//                         stat_lookups0_o, stat_lookups1_o, stat_stall_o.
// -----------------------------------------------------------------------------
module att_lookup_scheduler #(
    parameter int CLAUSE_COUNT               = 20,
    parameter int LITERAL_ADDRESS_WIDTH      = 12,
    parameter int CLAUSE_TABLE_ADDRESS_WIDTH = 11,
    parameter int STAT_WIDTH                 = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  cfg_lock_i,
    input  logic                                  req0_valid_i,
    input  logic [LITERAL_ADDRESS_WIDTH:0]        req0_lit_i,
    output logic                                  req0_ready_o,
    input  logic                                  req1_valid_i,
    input  logic [LITERAL_ADDRESS_WIDTH:0]        req1_lit_i,
    output logic                                  req1_ready_o,
    output logic [LITERAL_ADDRESS_WIDTH:0]        att_rd_addr_o,
    input  logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] att_addr_i,
    input  logic [CLAUSE_COUNT-1:0]               att_mask_i,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] rsp_addr_o,
    output logic [CLAUSE_COUNT-1:0]               rsp_mask_o,
    output logic                                  rsp_id_o,
    output logic [LITERAL_ADDRESS_WIDTH:0]        rsp_lit_o,
    output logic                                  busy_o
`ifdef ATT_LOOKUP_STATS_EN
    ,
    input  logic                                  stat_clr_i,
    output logic [STAT_WIDTH-1:0]                 stat_lookups0_o,
    output logic [STAT_WIDTH-1:0]                 stat_lookups1_o,
    output logic [STAT_WIDTH-1:0]                 stat_stall_o
`endif
);

    localparam int LIT_W = LITERAL_ADDRESS_WIDTH + 1;

    if (STAT_WIDTH < 1) begin : g_stat_width_check
        $error("att_lookup_scheduler: STAT_WIDTH must be at least 1");
    end

    typedef struct packed {
        logic [CLAUSE_TABLE_ADDRESS_WIDTH-1:0] addr;
        logic [CLAUSE_COUNT-1:0]               mask;
        logic                                  id;
        logic [LIT_W-1:0]                      lit;
    } entry_t;

    // Request side
    logic             pop;
    logic [2:0]       occupancy;
    logic             can_issue;
    logic             gnt0;
    logic             gnt1;
    logic             any_gnt;
    logic             last_gnt_q;     // requester granted most recently
    logic [LIT_W-1:0] rd_addr_q;

    // Table read stage
    logic             inflight_v_q;
    logic             inflight_id_q;
    logic [LIT_W-1:0] inflight_lit_q;

    // Response FIFO
    entry_t [1:0]     fifo_mem_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       fifo_count_q;
    entry_t           head;

    assign pop = rsp_valid_o & rsp_ready_i;

    // Slots that stay committed after this cycle's pop. A pop frees its slot
    // in the same cycle, which is what lets a full FIFO keep 1 lookup/cycle
    // going while rsp_ready_i is high.
    assign occupancy = {1'b0, fifo_count_q} + {2'b00, inflight_v_q} - {2'b00, pop};

    // rst_ni is folded in so the ready outputs are low throughout reset even
    // if requesters hold valid.
    assign can_issue = rst_ni & ~cfg_lock_i & (occupancy < 3'd2);

    // On a tie the requester not granted last wins; last_gnt_q resets to 1 so
    // req0 takes the first tie.
    assign gnt0    = can_issue & req0_valid_i & (~req1_valid_i | last_gnt_q);
    assign gnt1    = can_issue & req1_valid_i & (~req0_valid_i | ~last_gnt_q);
    assign any_gnt = gnt0 | gnt1;

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;

    always_comb begin
        att_rd_addr_o = rd_addr_q;
        if (gnt0) begin
            att_rd_addr_o = req0_lit_i;
        end else if (gnt1) begin
            att_rd_addr_o = req1_lit_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt_q     <= 1'b1;
            rd_addr_q      <= '0;
            inflight_v_q   <= 1'b0;
            inflight_id_q  <= 1'b0;
            inflight_lit_q <= '0;
            fifo_mem_q     <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            fifo_count_q   <= 2'd0;
        end else begin
            inflight_v_q <= any_gnt;
            if (any_gnt) begin
                last_gnt_q     <= gnt1;
                rd_addr_q      <= att_rd_addr_o;
                inflight_id_q  <= gnt1;
                inflight_lit_q <= att_rd_addr_o;
            end

            // Table data belongs to the lookup issued last cycle; the credit
            // check guarantees a free slot for it.
            if (inflight_v_q) begin
                fifo_mem_q[wr_ptr_q] <= '{addr: att_addr_i,
                                          mask: att_mask_i,
                                          id:   inflight_id_q,
                                          lit:  inflight_lit_q};
                wr_ptr_q <= ~wr_ptr_q;
            end

            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end

            case ({inflight_v_q, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    assign head        = fifo_mem_q[rd_ptr_q];
    assign rsp_valid_o = (fifo_count_q != 2'd0);
    assign rsp_addr_o  = head.addr;
    assign rsp_mask_o  = head.mask;
    assign rsp_id_o    = head.id;
    assign rsp_lit_o   = head.lit;
    assign busy_o      = inflight_v_q | (fifo_count_q != 2'd0);

`ifdef ATT_LOOKUP_STATS_EN
    logic [STAT_WIDTH-1:0] lookups0_q;
    logic [STAT_WIDTH-1:0] lookups1_q;
    logic [STAT_WIDTH-1:0] stall_q;
    logic                  stall;

    // A stall is a cycle with a pending request but no grant, whether the
    // cause is cfg_lock_i or a full pipeline.
    assign stall = (req0_valid_i | req1_valid_i) & ~any_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lookups0_q <= '0;
            lookups1_q <= '0;
            stall_q    <= '0;
        end else if (stat_clr_i) begin
            lookups0_q <= '0;
            lookups1_q <= '0;
            stall_q    <= '0;
        end else begin
            if (gnt0 && (lookups0_q != '1)) begin
                lookups0_q <= lookups0_q + STAT_WIDTH'(1);
            end
            if (gnt1 && (lookups1_q != '1)) begin
                lookups1_q <= lookups1_q + STAT_WIDTH'(1);
            end
            if (stall && (stall_q != '1)) begin
                stall_q <= stall_q + STAT_WIDTH'(1);
            end
        end
    end

    assign stat_lookups0_o = lookups0_q;
    assign stat_lookups1_o = lookups1_q;
    assign stat_stall_o    = stall_q;
`endif

endmodule
